// File: rtl/tron_collision_arbiter.sv
// tron_collision_arbiter: decides deaths from border/trail/head-on hits, plots trails, keeps score and wipes the arena.
module tron_collision_arbiter #(
    parameter int X_MIN = 10,
    parameter int X_MAX = 149,
    parameter int Y_MIN = 17,
    parameter int Y_MAX = 108,
    parameter logic [2:0] P1_COLOUR = 3'b001,
    parameter logic [2:0] P2_COLOUR = 3'b100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    input  logic [7:0] p1_x,
    input  logic [6:0] p1_y,
    input  logic [7:0] p2_x,
    input  logic [6:0] p2_y,
    output logic       busy,
    output logic       clearing,
    output logic [7:0] plot_x,
    output logic [6:0] plot_y,
    output logic [2:0] plot_colour,
    output logic       plot_en,
    output logic       result_valid,
    output logic [1:0] winner,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score
);
    localparam int W = X_MAX - X_MIN - 1;
    localparam int H = Y_MAX - Y_MIN - 1;
    localparam int N = W * H;
    localparam int AW = $clog2(N);
    localparam logic [7:0] XF = 8'(X_MIN + 1);
    localparam logic [7:0] XL = 8'(X_MAX - 1);
    localparam logic [6:0] YF = 7'(Y_MIN + 1);
    localparam logic [6:0] YL = 7'(Y_MAX - 1);

    typedef enum logic [2:0] {CLEAR, IDLE, RD1, RD2, EVAL, WR1, WR2, REPORT} state_t;
    state_t state, nxt;

    logic mem [N];
    logic rd_q, occ1, hv, we, wd, in1, in2, swap, head_on, k1, k2;
    logic [7:0] cx, l1x, l2x, h1x, h2x;
    logic [6:0] cy, l1y, l2y, h1y, h2y;
    logic [1:0] dead;
    logic [AW-1:0] a1, a2, ra, wa;

    function automatic logic interior(input logic [7:0] x, input logic [6:0] y);
        return int'(x) > X_MIN && int'(x) < X_MAX && int'(y) > Y_MIN && int'(y) < Y_MAX;
    endfunction

    function automatic logic [AW-1:0] addr(input logic [7:0] x, input logic [6:0] y);
        return AW'((int'(x) - X_MIN - 1) * H + int'(y) - Y_MIN - 1);
    endfunction

    assign in1 = interior(l1x, l1y);
    assign in2 = interior(l2x, l2y);
    assign a1 = in1 ? addr(l1x, l1y) : '0;
    assign a2 = in2 ? addr(l2x, l2y) : '0;
    // heads that swapped cells hit each other's old head, which is not a crash
    assign swap = hv && l1x == h2x && l1y == h2y && l2x == h1x && l2y == h1y;
    assign head_on = l1x == l2x && l1y == l2y;
    assign k1 = !in1 || head_on || (occ1 && !swap);
    assign k2 = !in2 || head_on || (rd_q && !swap);

    always_ff @(posedge clk) state <= reset ? CLEAR : nxt;

    always_comb begin
        nxt = state;
        case (state)
            CLEAR:   nxt = (cx == XL && cy == YL) ? IDLE : CLEAR;
            IDLE:    nxt = step ? RD1 : IDLE;
            RD1:     nxt = RD2;
            RD2:     nxt = EVAL;
            EVAL:    nxt = (k1 || k2) ? REPORT : WR1;
            WR1:     nxt = WR2;
            WR2:     nxt = IDLE;
            REPORT:  nxt = CLEAR;
            default: nxt = CLEAR;
        endcase
    end

    assign ra = (state == RD1) ? a1 : a2;
    assign we = !reset && (state == CLEAR || state == WR1 || state == WR2);
    assign wa = (state == CLEAR) ? addr(cx, cy) : (state == WR1) ? a1 : a2;
    assign wd = state != CLEAR;

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        rd_q <= mem[ra];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cx <= XF;
            cy <= YF;
            hv <= 1'b0;
            dead <= 2'b00;
            p1_score <= 4'd0;
            p2_score <= 4'd0;
        end else begin
            case (state)
                CLEAR: begin
                    hv <= 1'b0;
                    cy <= (cy == YL) ? YF : cy + 7'd1;
                    if (cy == YL) cx <= (cx == XL) ? XF : cx + 8'd1;
                end
                IDLE: if (step) begin
                    l1x <= p1_x;
                    l1y <= p1_y;
                    l2x <= p2_x;
                    l2y <= p2_y;
                end
                RD2: occ1 <= rd_q;
                EVAL: dead <= {k1, k2};
                WR2: begin
                    h1x <= l1x;
                    h1y <= l1y;
                    h2x <= l2x;
                    h2y <= l2y;
                    hv <= 1'b1;
                end
                REPORT: begin
                    if (dead == 2'b01 && p1_score != 4'd15) p1_score <= p1_score + 4'd1;
                    if (dead == 2'b10 && p2_score != 4'd15) p2_score <= p2_score + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy = state != IDLE;
    assign clearing = state == CLEAR;
    assign plot_en = !reset && (state == CLEAR || state == WR1 || state == WR2);
    assign plot_x = (state == CLEAR) ? cx : (state == WR1) ? l1x : (state == WR2) ? l2x : 8'd0;
    assign plot_y = (state == CLEAR) ? cy : (state == WR1) ? l1y : (state == WR2) ? l2y : 7'd0;
    assign plot_colour = (state == WR1) ? P1_COLOUR : (state == WR2) ? P2_COLOUR : 3'b000;
    assign result_valid = state == REPORT;
    assign winner = (state == REPORT) ? dead : 2'b00;
endmodule

// File: tb/tb_tron_collision_arbiter.sv
// tb_tron_collision_arbiter: cycle-accurate expectation queue built from the game rules, plus literal checks.
module tb_tron_collision_arbiter;
    localparam int X_MIN = 10, X_MAX = 149, Y_MIN = 17, Y_MAX = 108;

    logic clk = 1'b0, reset = 1'b1, step = 1'b0;
    logic [7:0] p1_x = 8'd0, p2_x = 8'd0;
    logic [6:0] p1_y = 7'd0, p2_y = 7'd0;
    logic busy, clearing, plot_en, result_valid;
    logic [7:0] plot_x;
    logic [6:0] plot_y;
    logic [2:0] plot_colour;
    logic [1:0] winner;
    logic [3:0] p1_score, p2_score;

    logic s_step = 1'b0;
    logic [7:0] s_p1x = 8'd0, s_p2x = 8'd0, s_px;
    logic [6:0] s_p1y = 7'd0, s_p2y = 7'd0, s_py;
    logic s_busy, s_clr, s_pen, s_rv;
    logic [2:0] s_pc;
    logic [1:0] s_win;
    logic [3:0] s_s1, s_s2;

    always #5 clk = ~clk;

    tron_collision_arbiter dut (
        .clk(clk), .reset(reset), .step(step),
        .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
        .busy(busy), .clearing(clearing), .plot_x(plot_x), .plot_y(plot_y),
        .plot_colour(plot_colour), .plot_en(plot_en), .result_valid(result_valid),
        .winner(winner), .p1_score(p1_score), .p2_score(p2_score)
    );

    tron_collision_arbiter #(.X_MIN(0), .X_MAX(4), .Y_MIN(0), .Y_MAX(4)) dut_s (
        .clk(clk), .reset(reset), .step(s_step),
        .p1_x(s_p1x), .p1_y(s_p1y), .p2_x(s_p2x), .p2_y(s_p2y),
        .busy(s_busy), .clearing(s_clr), .plot_x(s_px), .plot_y(s_py),
        .plot_colour(s_pc), .plot_en(s_pen), .result_valid(s_rv),
        .winner(s_win), .p1_score(s_s1), .p2_score(s_s2)
    );

    typedef struct {
        bit busy, clr, pen, rv;
        int px, py, pc, win, s1, s2;
    } rec_t;

    rec_t exp_q[$];
    bit occ [0:255][0:127];
    bit pv, m_idle;
    int q1x, q1y, q2x, q2y, ms1, ms2;
    int tests = 0, fails = 0;

    task automatic chk(input string n, input int a, input int e);
        tests++;
        if (a != e) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", n, $time, a, e);
        end
    endtask

    function automatic void push(input bit b, input bit c, input bit p, input int x, input int y,
                                 input int col, input bit rv, input int w);
        rec_t r;
        r.busy = b; r.clr = c; r.pen = p; r.px = x; r.py = y; r.pc = col;
        r.rv = rv; r.win = w; r.s1 = ms1; r.s2 = ms2;
        exp_q.push_back(r);
    endfunction

    function automatic bit lethal_border(input int x, input int y);
        return x <= X_MIN || x >= X_MAX || y <= Y_MIN || y >= Y_MAX;
    endfunction

    function automatic void model_clear();
        for (int x = X_MIN + 1; x < X_MAX; x++)
            for (int y = Y_MIN + 1; y < Y_MAX; y++) begin
                push(1, 1, 1, x, y, 0, 0, 0);
                occ[x][y] = 0;
            end
        pv = 0;
    endfunction

    function automatic void model_step(input int x1, input int y1, input int x2, input int y2);
        bit sw, d1, d2;
        sw = pv && x1 == q2x && y1 == q2y && x2 == q1x && y2 == q1y;
        d1 = lethal_border(x1, y1) || (!sw && occ[x1][y1]) || (x1 == x2 && y1 == y2);
        d2 = lethal_border(x2, y2) || (!sw && occ[x2][y2]) || (x1 == x2 && y1 == y2);
        repeat (3) push(1, 0, 0, 0, 0, 0, 0, 0);
        if (!d1 && !d2) begin
            push(1, 0, 1, x1, y1, 1, 0, 0);
            push(1, 0, 1, x2, y2, 4, 0, 0);
            occ[x1][y1] = 1;
            occ[x2][y2] = 1;
            pv = 1; q1x = x1; q1y = y1; q2x = x2; q2y = y2;
        end else begin
            push(1, 0, 0, 0, 0, 0, 1, d1 * 2 + d2);
            if (d1 && !d2) ms2 = (ms2 == 15) ? 15 : ms2 + 1;
            if (d2 && !d1) ms1 = (ms1 == 15) ? 15 : ms1 + 1;
            model_clear();
        end
    endfunction

    initial begin
        rec_t e;
        m_idle = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (reset) begin
                m_idle = 0;
                chk("rst_busy", busy, 1);
                chk("rst_clearing", clearing, 1);
                chk("rst_plot_en", plot_en, 0);
                chk("rst_result", result_valid, 0);
                chk("rst_winner", winner, 0);
                chk("rst_p1_score", p1_score, 0);
                chk("rst_p2_score", p2_score, 0);
            end else if (exp_q.size() == 0) begin
                m_idle = 1;
                chk("idle_busy", busy, 0);
                chk("idle_plot_en", plot_en, 0);
                chk("idle_result", result_valid, 0);
                chk("idle_p1_score", p1_score, ms1);
                chk("idle_p2_score", p2_score, ms2);
            end else begin
                m_idle = 0;
                e = exp_q.pop_front();
                chk("busy", busy, e.busy);
                chk("clearing", clearing, e.clr);
                chk("plot_en", plot_en, e.pen);
                if (e.pen) begin
                    chk("plot_x", plot_x, e.px);
                    chk("plot_y", plot_y, e.py);
                    chk("plot_colour", plot_colour, e.pc);
                end
                chk("result_valid", result_valid, e.rv);
                chk("winner", winner, e.win);
                chk("p1_score", p1_score, e.s1);
                chk("p2_score", p2_score, e.s2);
            end
        end
    end

    task automatic step_pair(input int x1, input int y1, input int x2, input int y2);
        @(negedge clk);
        #1;
        p1_x = 8'(x1); p1_y = 7'(y1); p2_x = 8'(x2); p2_y = 7'(y2);
        step = 1'b1;
        if (m_idle) model_step(x1, y1, x2, y2);
        @(posedge clk);
        #1 step = 1'b0;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (!busy) break;
            if (plot_en) cnt++;
        end
        chk("wait_idle", busy, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        ms1 = 0; ms2 = 0; pv = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
    endtask

    initial begin
        int cnt, w;
        bit got;
        ms1 = 0; ms2 = 0; pv = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
        wait_idle(cnt);
        chk("clear_len", cnt, 12420);

        step_pair(25, 100, 135, 100);
        repeat (4) @(negedge clk);
        #1;
        chk("p1_plot_en", plot_en, 1);
        chk("p1_plot_x", plot_x, 25);
        chk("p1_plot_y", plot_y, 100);
        chk("p1_colour", plot_colour, 1);
        @(negedge clk);
        #1;
        chk("p2_plot_x", plot_x, 135);
        chk("p2_colour", plot_colour, 4);
        wait_idle(cnt);

        step_pair(40, 40, 41, 40);
        wait_idle(cnt);
        step_pair(41, 40, 40, 40);
        wait_idle(cnt);
        chk("cross_plots", cnt, 2);

        step_pair(25, 100, 136, 100);
        repeat (4) @(negedge clk);
        #1;
        chk("trail_result", result_valid, 1);
        chk("trail_winner", winner, 2);
        chk("trail_p2_old", p2_score, 0);
        @(negedge clk);
        #1;
        chk("trail_clearing", clearing, 1);
        chk("trail_p2_new", p2_score, 1);
        step_pair(30, 30, 31, 30);
        wait_idle(cnt);

        step_pair(10, 50, 60, 60);
        repeat (4) @(negedge clk);
        #1;
        chk("border_winner", winner, 2);
        wait_idle(cnt);
        chk("border_p2", p2_score, 2);

        step_pair(80, 60, 80, 60);
        repeat (4) @(negedge clk);
        #1;
        chk("draw_winner", winner, 3);
        chk("draw_p1", p1_score, 0);
        repeat (100) @(negedge clk);
        do_reset();
        wait_idle(cnt);
        chk("reclear_len", cnt, 12420);
        chk("reclear_p2", p2_score, 0);

        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            #1;
            s_p1x = 8'd2; s_p1y = 7'd2; s_p2x = 8'd0; s_p2y = 7'd2;
            s_step = 1'b1;
            @(posedge clk);
            #1 s_step = 1'b0;
            got = 0;
            w = 0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge clk);
                if (s_rv) begin
                    got = 1;
                    w = int'(s_win);
                end
            end
            chk("s_result", got, 1);
            chk("s_winner", w, 1);
            for (int k = 0; k < 50 && s_busy; k++) @(negedge clk);
            chk("s_idle", s_busy, 0);
            chk("s_p1_score", s_s1, (i > 15) ? 15 : i);
        end
        chk("s_p2_score", s_s2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tron_collision_arbiter.md
TRON_COLLISION_ARBITER -- requirements
Module: tron_collision_arbiter

Interface
REQ-001 SHALL have parameter X_MIN, default 10, meaning leftmost border column (lethal).
REQ-002 SHALL have parameter X_MAX, default 149, meaning rightmost border column (lethal).
REQ-003 SHALL have parameter Y_MIN, default 17, meaning top border row (lethal).
REQ-004 SHALL have parameter Y_MAX, default 108, meaning bottom border row (lethal).
REQ-005 SHALL have parameter P1_COLOUR, default 3'b001, meaning player-1 trail colour.
REQ-006 SHALL have parameter P2_COLOUR, default 3'b100, meaning player-2 trail colour.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port step, input, 1 bit: one-cycle pulse meaning both heads advanced.
REQ-010 SHALL have ports p1_x, input, 8 bits, and p1_y, input, 7 bits: player-1 head position.
REQ-011 SHALL have ports p2_x, input, 8 bits, and p2_y, input, 7 bits: player-2 head position.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-013 SHALL have port clearing, output, 1 bit: high during arena wipe; drives the datapaths' reposition input.
REQ-014 SHALL have ports plot_x (output, 8 bits), plot_y (output, 7 bits), plot_colour (output, 3 bits) and plot_en (output, 1 bit): the VGA pixel-write request.
REQ-015 SHALL have port result_valid, output, 1 bit: one-cycle pulse when a round ends.
REQ-016 SHALL have port winner, output, 2 bits: 01 P1 wins, 10 P2 wins, 11 draw; valid with result_valid.
REQ-017 SHALL have ports p1_score and p2_score, output, 4 bits each: round-win counters.

Function
REQ-018 SHALL hold a 1-bit occupancy map for interior cells X_MIN+1..X_MAX-1 by Y_MIN+1..Y_MAX-1, with synchronous read (1-cycle latency).
REQ-019 SHALL implement states CLEAR, IDLE, RD1, RD2, EVAL, WR1, WR2, REPORT.
REQ-020 IDLE: step=1 SHALL latch all four coordinates and go to RD1; step in any other state SHALL be ignored.
REQ-021 RD1 SHALL issue the read of the latched P1 cell; RD2 SHALL capture the P1 occupancy and issue the read of the P2 cell; EVAL SHALL capture the P2 occupancy.
REQ-022 EVAL SHALL mark a player dead if any of these hold: the head lies on or outside a border row or column; the head cell is occupied; or the two heads are equal (head-on).
REQ-023 Border or outside-border heads SHALL NOT address the map; such a read result SHALL be treated as don't-care.
REQ-024 With no death: WR1 SHALL set the P1 cell and plot it in P1_COLOUR, WR2 SHALL do the same for P2 in P2_COLOUR, then the FSM returns to IDLE.
REQ-025 The first P1 plot_en SHALL occur exactly 4 cycles after the step cycle, and the FSM SHALL be back in IDLE 6 cycles after step.
REQ-026 With any death: REPORT SHALL pulse result_valid for 1 cycle with winner set (P1 dead only gives 10, P2 dead only gives 01, both dead gives 11), then go to CLEAR.
REQ-027 In REPORT, the surviving player's score SHALL increment, saturating at 15; a draw SHALL change no score.
REQ-028 CLEAR SHALL sweep x outer (X_MIN+1..X_MAX-1) and y inner (Y_MIN+1..Y_MAX-1), one cell per cycle, zeroing the map and plotting colour 3'b000 with plot_en=1.
REQ-029 The CLEAR sweep SHALL take exactly 138*90 = 12420 cycles at default parameters, then go to IDLE.
REQ-030 plot_en SHALL be 0 in IDLE, RD1, RD2, EVAL and REPORT.
REQ-031 Crossing paths in one step (the heads swap cells) SHALL NOT count as a collision.

Reset
REQ-032 During reset: state=CLEAR from its first cell, scores=0, result_valid=0, winner=00, plot_en=0.
REQ-033 Deasserting reset SHALL start a full CLEAR sweep, with clearing=1 and busy=1 until it completes.
REQ-034 Reset asserted mid-operation, including mid-CLEAR, SHALL restart as in REQ-032 with no result pulse.

Verification
REQ-035 Reset, then wait 12420 cycles: every interior cell is plotted 3'b000 once, then busy=0.
REQ-036 Step with P1 at (25,100) and P2 at (135,100): plot (25,100)/001 at step+4 and (135,100)/100 at step+5, no result.
REQ-037 Repeat the REQ-036 step with P1 still at (25,100): result_valid with winner=10, p2_score goes 0 to 1, clearing=1 next cycle.
REQ-038 Step with P1 at (10,50) and P2 on (60,60) (a free cell): winner=10, and (10,50) is never written to the map.
REQ-039 Step with both heads at (80,60): winner=11, both scores unchanged.
REQ-040 Step pulses during busy are ignored; 16 consecutive P1 wins leave p1_score=15.
